// File: rtl/mem_hexdump.sv
// mem_hexdump: hardware hex/ASCII memory dumper.
//
// On i_start the block latches a byte window, walks it row by row through a
// single-cycle-latency read port and streams a formatted text dump on a
// valid/ready byte stream. Each row is printed as:
//   '\n' AAAA ':' { ' ' before each group } hh hh ... [ "  " ASCII column ]
// and one final '\n' ends the dump.
//
// Optional feature macro: MEM_HEXDUMP_ASCII_EN
//   defined   : two-space gap plus ASCII column, replayed from a row buffer
//   undefined : rows end after the last hex pair, no row buffer
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active-high (aborts a dump, no done)
//   i_start      pulse: latch i_addr/i_len and begin (ignored while busy)
//   i_addr       first byte of the window
//   i_len        byte count, 0 = empty dump
//   o_mem_rd     memory read strobe
//   o_mem_addr   memory read address
//   i_mem_data   read data, valid the cycle after o_mem_rd
//   o_out_valid  o_out_char valid
//   i_out_ready  sink accepts o_out_char this cycle
//   o_out_char   ASCII output character
//   o_busy       dump in progress
//   o_done       1-cycle pulse after the final character is accepted
module mem_hexdump #(
  parameter int unsigned AW        = 17,
  parameter int unsigned ROW_BYTES = 16,
  parameter int unsigned GROUP     = 4,
  parameter int unsigned ADDR_DIG  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_len,
  output logic          o_mem_rd,
  output logic [AW-1:0] o_mem_addr,
  input  logic [7:0]    i_mem_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [7:0]    o_out_char,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned IW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam logic [AW-1:0] RowMask = ~AW'(ROW_BYTES - 1);
  localparam logic [AW-1:0] RowStep = AW'(ROW_BYTES);
  localparam logic [IW-1:0] IdxLast = IW'(ROW_BYTES - 1);
  localparam logic [3:0]    DigLast = 4'(ADDR_DIG - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_NL, S_ADDR, S_COLON, S_SEP, S_FETCH, S_WAIT,
    S_HI, S_LO, S_GAP, S_ASC, S_EOL, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_row, w_row_nxt;          // current row base address
  logic [AW-1:0] r_last_row, w_last_row_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;          // byte index within the row
  logic [3:0]    r_cnt, w_cnt_nxt;          // address digit / gap counter
  logic [7:0]    r_byte, w_byte_nxt;        // byte being printed in hex

  logic [AW:0]   w_last_full;
  logic [AW-1:0] w_last_sat;
  logic [IW-1:0] w_idx_inc;
  logic          w_grp_next;
  logic [3:0]    w_nib;
  logic          w_last_row;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // End of the window, saturated so a window running off the top of memory
  // stops at the last address instead of wrapping.
  assign w_last_full = {1'b0, i_addr} + {1'b0, i_len} - {{AW{1'b0}}, 1'b1};
  assign w_last_sat  = w_last_full[AW] ? {AW{1'b1}} : w_last_full[AW-1:0];

  assign w_idx_inc  = r_idx + IW'(1);
  assign w_grp_next = ((32'(w_idx_inc) % GROUP) == 32'd0);
  assign w_nib      = 4'(r_row >> {r_cnt, 2'b00});
  assign w_last_row = (r_row == r_last_row);

`ifdef MEM_HEXDUMP_ASCII_EN
  logic [7:0] r_buf [ROW_BYTES];
  logic [7:0] w_asc_byte;

  // Row buffer feeds the ASCII column so memory is read only once per byte.
  always_ff @(posedge i_clk) begin
    if (r_state == S_WAIT) begin
      r_buf[r_idx] <= i_mem_data;
    end
  end

  assign w_asc_byte = r_buf[r_idx];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_last_row <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_byte     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_last_row <= w_last_row_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_byte     <= w_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_last_row_nxt = r_last_row;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_byte_nxt     = r_byte;
    o_mem_rd       = 1'b0;
    o_mem_addr     = '0;
    o_out_valid    = 1'b0;
    o_out_char     = 8'h00;
    o_done         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_row_nxt      = i_addr & RowMask;
            w_last_row_nxt = w_last_sat & RowMask;
            w_state_nxt    = S_NL;
          end
        end
      end
      S_NL: begin
        o_out_valid = 1'b1;
        o_out_char  = 8'h0a;
        if (i_out_ready) begin
          w_cnt_nxt   = DigLast;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        o_out_valid = 1'b1;
        o_out_char  = hex_char(w_nib);
        if (i_out_ready) begin
          if (r_cnt == 4'd0) w_state_nxt = S_COLON;
          else               w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_COLON: begin
        o_out_valid = 1'b1;
        o_out_char  = 8'h3a;
        if (i_out_ready) begin
          // Byte 0 always starts a group.
          w_idx_nxt   = '0;
          w_state_nxt = S_SEP;
        end
      end
      S_SEP: begin
        o_out_valid = 1'b1;
        o_out_char  = 8'h20;
        if (i_out_ready) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_mem_rd    = 1'b1;
        o_mem_addr  = r_row + AW'(r_idx);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_byte_nxt  = i_mem_data;
        w_state_nxt = S_HI;
      end
      S_HI: begin
        o_out_valid = 1'b1;
        o_out_char  = hex_char(r_byte[7:4]);
        if (i_out_ready) w_state_nxt = S_LO;
      end
      S_LO: begin
        o_out_valid = 1'b1;
        o_out_char  = hex_char(r_byte[3:0]);
        if (i_out_ready) begin
          if (r_idx == IdxLast) begin
`ifdef MEM_HEXDUMP_ASCII_EN
            w_cnt_nxt   = 4'd1;
            w_state_nxt = S_GAP;
`else
            if (w_last_row) begin
              w_state_nxt = S_EOL;
            end else begin
              w_row_nxt   = r_row + RowStep;
              w_state_nxt = S_NL;
            end
`endif
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = w_grp_next ? S_SEP : S_FETCH;
          end
        end
      end
`ifdef MEM_HEXDUMP_ASCII_EN
      S_GAP: begin
        o_out_valid = 1'b1;
        o_out_char  = 8'h20;
        if (i_out_ready) begin
          if (r_cnt == 4'd0) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_ASC;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      S_ASC: begin
        o_out_valid = 1'b1;
        o_out_char  = (w_asc_byte < 8'h20 || w_asc_byte >= 8'h7f) ? 8'h2e : w_asc_byte;
        if (i_out_ready) begin
          if (r_idx == IdxLast) begin
            if (w_last_row) begin
              w_state_nxt = S_EOL;
            end else begin
              w_row_nxt   = r_row + RowStep;
              w_state_nxt = S_NL;
            end
          end else begin
            w_idx_nxt = w_idx_inc;
          end
        end
      end
`endif
      S_EOL: begin
        o_out_valid = 1'b1;
        o_out_char  = 8'h0a;
        if (i_out_ready) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_mem_hexdump.sv
// tb_mem_hexdump: scoreboard bench for mem_hexdump. Expected characters are
// built from the bench's own memory image and queued when a dump is started;
// the output monitor pops and compares each accepted character.
module tb_mem_hexdump;

  localparam int AW    = 17;
  localparam int RB    = 16;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [AW-1:0] len = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_char;
  logic          busy;
  logic          done;

  logic [7:0] mem [MSIZE];
  logic [7:0] exp_q[$];
  int         rd_map[int];
  int         rd_total;
  int         done_cnt;
  int         n_acc;
  int         any_valid;
  bit         rnd_ready = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_char = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  mem_hexdump dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_addr      (addr),
    .i_len       (len),
    .o_mem_rd    (mem_rd),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_char  (out_char),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h57 + n);
  endfunction

  // Synchronous read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  // Ready driver: held high or randomly toggled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_char", {24'd0, out_char}, {24'd0, prev_char});
      end
      if (out_valid) any_valid++;
      if (out_valid && out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) check("extra_char", {24'd0, out_char}, 32'hffff_ffff);
        else check("char", {24'd0, out_char}, {24'd0, exp_q.pop_front()});
      end
      prev_hold = out_valid && !out_ready;
      prev_char = out_char;
      if (done) done_cnt++;
      if (mem_rd) begin
        rd_total++;
        if (rd_map.exists(int'(mem_addr))) rd_map[int'(mem_addr)] += 1;
        else rd_map[int'(mem_addr)] = 1;
      end
      if (busy) check("rd_while_valid", {31'd0, mem_rd & out_valid}, 32'd0);
    end
  end

  // Expected dump of a window; returns the number of rows.
  task automatic push_dump(input int a, input int l, output int rows, output int a0);
    int last, last_row;
    rows = 0;
    a0 = a & ~(RB - 1);
    if (l == 0) return;
    last = a + l - 1;
    if (last > MSIZE - 1) last = MSIZE - 1;
    last_row = last & ~(RB - 1);
    for (int r = a0; r <= last_row; r += RB) begin
      rows++;
      exp_q.push_back(8'h0a);
      for (int d = 3; d >= 0; d--) exp_q.push_back(hexc((r >> (4 * d)) & 15));
      exp_q.push_back(8'h3a);
      for (int b = 0; b < RB; b++) begin
        if (b % 4 == 0) exp_q.push_back(8'h20);
        exp_q.push_back(hexc(int'(mem[r + b]) >> 4));
        exp_q.push_back(hexc(int'(mem[r + b]) & 15));
      end
`ifdef MEM_HEXDUMP_ASCII_EN
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h20);
      for (int b = 0; b < RB; b++) begin
        if (mem[r + b] < 8'h20 || mem[r + b] >= 8'h7f) exp_q.push_back(8'h2e);
        else exp_q.push_back(mem[r + b]);
      end
`endif
    end
    exp_q.push_back(8'h0a);
  endtask

  task automatic pulse_start(input int a, input int l);
    @(posedge clk);
    #1;
    addr  = AW'(a);
    len   = AW'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_stats();
    rd_map.delete();
    rd_total  = 0;
    done_cnt  = 0;
    n_acc     = 0;
    any_valid = 0;
  endtask

  // Wait for done within a cycle budget; a missed done counts as a failure.
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_done_seen"}, {31'd0, done_cnt > 0}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input string tag, input int a, input int l, input bit poke);
    int rows, a0;
    clear_stats();
    push_dump(a, l, rows, a0);
    pulse_start(a, l);
    if (poke) begin
      // A second start while busy must be ignored.
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      addr  = '0;
      len   = AW'(5);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(tag);
    check({tag, "_queue_left"}, exp_q.size(), 32'd0);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_rd_total"}, rd_total, rows * RB);
    for (int i = 0; i < rows * RB; i++) begin
      int ad = (a0 + i) % MSIZE;
      check({tag, "_rd_once"}, rd_map.exists(ad) ? rd_map[ad] : 0, 32'd1);
    end
    exp_q.delete();
  endtask

  initial begin
    int cyc, total, rows, a0;
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < RB; i++) mem['h1000 + i] = 8'(8'h41 + i);
    mem['h1011] = 8'h0a;
    mem['h1012] = 8'h80;
    mem['h1013] = 8'h7f;
    mem['h1014] = 8'h20;
    mem['h1015] = 8'h7e;
    mem['h1016] = 8'h1f;
    clear_stats();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_char", {24'd0, out_char}, 32'd0);
    // start coincident with reset must be ignored.
    start = 1'b1;
    addr  = AW'('h1000);
    len   = AW'(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_wins_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single row, ready held high.
    run_dump("t1", 'h1003, 2, 1'b0);
    // Two rows, non-printable bytes, plus a start while busy.
    run_dump("t2", 'h100e, 4, 1'b1);
    // Window running off the top of memory saturates.
    run_dump("wrap", 'h1fff8, 'h10, 1'b0);

    // Empty dump.
    clear_stats();
    pulse_start('h1000, 0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("len0_done_low", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_valid", any_valid, 32'd0);
    check("len0_done_pulses", done_cnt, 32'd1);

    // Random stalls.
    rnd_ready = 1'b1;
    run_dump("t4", 'h1003, 2, 1'b0);
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset near the end of the row (inside the ASCII column when present).
    clear_stats();
    push_dump('h1003, 2, rows, a0);
    total = exp_q.size();
    pulse_start('h1003, 2);
    cyc = 0;
    while (n_acc < total - 4 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t5_reached", {31'd0, n_acc >= total - 4}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, 32'd0);
    run_dump("t5_again", 'h1003, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
